// File: rtl/led_mode_ctrl_pkg.sv
// Shared mode encoding and LED patterns for led_mode_ctrl.
// Imported by the top and by key_debounce.
package led_mode_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 2'd0,
    MODE_ALT  = 2'd1,
    MODE_SYNC = 2'd2,
    MODE_ON   = 2'd3
  } mode_e;

  localparam logic [1:0] LED_NONE = 2'b00;
  localparam logic [1:0] LED_L0   = 2'b01;
  localparam logic [1:0] LED_L1   = 2'b10;
  localparam logic [1:0] LED_BOTH = 2'b11;

  function automatic logic [1:0] led_pattern(
    input mode_e m,
    input logic  ph
  );
    logic [1:0] p;
    p = LED_NONE;
    unique case (m)
      MODE_OFF:  p = LED_NONE;
      MODE_ALT:  p = ph ? LED_L1 : LED_L0;
      MODE_SYNC: p = ph ? LED_NONE : LED_BOTH;
      MODE_ON:   p = LED_BOTH;
      default:   p = LED_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_debounce.sv
// key_debounce: 2-flop sync, stable-time debounce, press pulse.
// Level resets to released so a key held at reset yields one press.
module key_debounce
  import led_mode_ctrl_pkg::*;
#(
  parameter logic [19:0] DEB_MAX = 20'd1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_lvl,
  output logic key_press
);

  logic        sync1_q, sync2_q;
  logic        lvl_q, lvl_d;
  logic        press_q, press_d;
  logic [19:0] cnt_q, cnt_d;

  // bring the raw key into the sys_clk domain
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // count stable cycles of a differing synced value, then adopt it
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q >= DEB_MAX - 20'd1) begin
      cnt_d   = '0;
      lvl_d   = sync2_q;
      press_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  // debounce state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign key_lvl   = lvl_q;
  assign key_press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: key-stepped LED pattern FSM with timebase.
// LED_SPEED_EN: key1 cycles a speed divisor instead of pausing.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter logic [24:0] CNT_MAX = 25'd25_000_000,
  parameter logic [19:0] DEB_MAX = 20'd1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] key,
  output logic [1:0] led,
  output logic [1:0] mode
);

  logic [1:0]  press;
  logic [1:0]  key_lvl_unused;
  logic        both;
  mode_e       mode_q, mode_d;
  logic        phase_q, phase_d;
  logic [24:0] tb_cnt_q, tb_cnt_d;
  logic [24:0] period;
  logic        tick;
  logic        paused;
  logic [1:0]  led_q, led_d;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(
      .DEB_MAX(DEB_MAX)
    ) u_deb (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_in   (key[i]),
      .key_lvl  (key_lvl_unused[i]),
      .key_press(press[i])
    );
  end

  assign both = press[0] & press[1];

`ifdef LED_SPEED_EN
  logic [1:0] speed_q, speed_d;

  // key1 steps the speed; both keys together restore full period
  always_comb begin
    speed_d = speed_q;
    if (both)
      speed_d = 2'd0;
    else if (press[1])
      speed_d = speed_q + 2'd1;
  end

  // speed register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      speed_q <= 2'd0;
    else
      speed_q <= speed_d;
  end

  assign paused = 1'b0;
  assign period = CNT_MAX >> speed_q;
`else
  logic paused_q, paused_d;

  // key1 toggles pause; both keys together force run
  always_comb begin
    paused_d = paused_q;
    if (both)
      paused_d = 1'b0;
    else if (press[1])
      paused_d = ~paused_q;
  end

  // pause register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      paused_q <= 1'b0;
    else
      paused_q <= paused_d;
  end

  assign paused = paused_q;
  assign period = CNT_MAX;
`endif

  // >= so a shrinking period wraps immediately
  assign tick = tb_cnt_q >= period - 25'd1;

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      mode_q <= MODE_OFF;
    else
      mode_q <= mode_d;
  end

  // FSM next state: key0 advances, both keys reset to OFF
  always_comb begin
    mode_d = mode_q;
    if (both)
      mode_d = MODE_OFF;
    else if (press[0])
      mode_d = mode_e'(mode_q + 2'd1);
  end

  // timebase: restart on mode change, hold while paused
  always_comb begin
    tb_cnt_d = tb_cnt_q;
    phase_d  = phase_q;
    if (press[0]) begin
      tb_cnt_d = '0;
      phase_d  = 1'b0;
    end else if (!paused) begin
      if (tick) begin
        tb_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        tb_cnt_d = tb_cnt_q + 25'd1;
      end
    end
  end

  // timebase registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tb_cnt_q <= '0;
      phase_q  <= 1'b0;
    end else begin
      tb_cnt_q <= tb_cnt_d;
      phase_q  <= phase_d;
    end
  end

  // FSM output decode
  always_comb begin
    led_d = led_pattern(mode_q, phase_q);
  end

  // registered LED drive
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      led_q <= LED_NONE;
    else
      led_q <= led_d;
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with CNT_MAX=10, DEB_MAX=4.
// Table of key steps plus hand sequences for pause/both/reset.
module tb_led_mode_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [1:0] key;
  logic [1:0] led;
  logic [1:0] mode;

  always #5 sys_clk = ~sys_clk;

  led_mode_ctrl #(
    .CNT_MAX(25'd10),
    .DEB_MAX(20'd4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .led      (led),
    .mode     (mode)
  );

  typedef struct {
    logic [1:0] k;
    int         hold;
    logic [1:0] m;
    logic [1:0] la;
    logic [1:0] lb;
    int         per;
  } vec_t;

  typedef struct {
    logic [1:0] m;
    logic [1:0] la;
    logic [1:0] lb;
    int         per;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic hold_key(input logic [1:0] k, input int n);
    key = k;
    repeat (n) @(negedge sys_clk);
    key = 2'b11;
    repeat (12) @(negedge sys_clk);
  endtask

  task automatic measure(output int per, output logic [1:0] v1,
                         output logic [1:0] v2);
    logic [1:0] p;
    int n;
    p = led;
    n = 0;
    while (led === p && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    v1 = led;
    p  = led;
    n  = 0;
    while (led === p && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    per = (n >= 40) ? -1 : n;
    v2  = led;
  endtask

  task automatic check_pat(input string nm, input exp_t e);
    int per;
    logic [1:0] v1, v2, seen;
    chk({nm, " mode"}, 32'(mode), 32'(e.m));
    if (e.per == 0) begin
      seen = e.la;
      repeat (30) begin
        @(negedge sys_clk);
        if (led !== e.la) seen = led;
      end
      chk({nm, " led steady"}, 32'(seen), 32'(e.la));
    end else begin
      measure(per, v1, v2);
      chk({nm, " period"}, per, e.per);
      if (v1 === e.la)
        chk({nm, " pair"}, 32'({v1, v2}), 32'({e.la, e.lb}));
      else
        chk({nm, " pair"}, 32'({v1, v2}), 32'({e.lb, e.la}));
    end
  endtask

  task automatic step(input string nm, input vec_t v);
    exp_t e, got;
    e.m   = v.m;
    e.la  = v.la;
    e.lb  = v.lb;
    e.per = v.per;
    sbq.push_back(e);
    hold_key(v.k, v.hold);
    got = sbq.pop_front();
    check_pat(nm, got);
  endtask

  function automatic vec_t mk(input logic [1:0] k, input int h,
                              input logic [1:0] m, input logic [1:0] a,
                              input logic [1:0] b, input int p);
    vec_t v;
    v.k = k; v.hold = h; v.m = m; v.la = a; v.lb = b; v.per = p;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = mk(2'b10, 3,  2'd0, 2'b00, 2'b00, 0);
    vt[1] = mk(2'b10, 10, 2'd1, 2'b01, 2'b10, 10);
    vt[2] = mk(2'b10, 10, 2'd2, 2'b11, 2'b00, 10);
    vt[3] = mk(2'b10, 10, 2'd3, 2'b11, 2'b11, 0);
    vt[4] = mk(2'b10, 10, 2'd0, 2'b00, 2'b00, 0);
    vt[5] = mk(2'b10, 10, 2'd1, 2'b01, 2'b10, 10);

    key       = 2'b11;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("in reset led", 32'(led), 0);
    chk("in reset mode", 32'(mode), 0);
    sys_rst_n = 1'b1;
    check_pat("idle", '{m: 2'd0, la: 2'b00, lb: 2'b00, per: 0});

    for (int i = 0; i < 6; i++)
      step($sformatf("vec%0d", i), vt[i]);

`ifdef LED_SPEED_EN
    begin
      int pers[4];
      pers = '{5, 2, 1, 10};
      for (int i = 0; i < 4; i++)
        step($sformatf("speed%0d", i),
             mk(2'b01, 10, 2'd1, 2'b01, 2'b10, pers[i]));
    end
`else
    n = 0;
    while (led === 2'b10 && n < 40) begin @(negedge sys_clk); n++; end
    while (led !== 2'b10 && n < 80) begin @(negedge sys_clk); n++; end
    chk("wait phase1", 32'(led), 32'(2'b10));
    hold_key(2'b01, 10);
    check_pat("paused", '{m: 2'd1, la: 2'b10, lb: 2'b10, per: 0});
    check_pat("paused2", '{m: 2'd1, la: 2'b10, lb: 2'b10, per: 0});
    step("resume", mk(2'b01, 10, 2'd1, 2'b01, 2'b10, 10));
    step("to sync", mk(2'b10, 10, 2'd2, 2'b11, 2'b00, 10));
    hold_key(2'b01, 10);
    chk("sync paused mode", 32'(mode), 2);
    step("both", mk(2'b00, 10, 2'd0, 2'b00, 2'b00, 0));
    step("after both", mk(2'b10, 10, 2'd1, 2'b01, 2'b10, 10));
`endif

    @(negedge sys_clk);
    chk("pre reset mode", 32'(mode), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async reset led", 32'(led), 0);
    chk("async reset mode", 32'(mode), 0);
    key = 2'b10;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("held through reset mode", 32'(mode), 1);
    key = 2'b11;
    repeat (12) @(negedge sys_clk);
    check_pat("held single press",
              '{m: 2'd1, la: 2'b01, lb: 2'b10, per: 10});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
